// File: rtl/imem_fetch_pkg.sv
// rtl/imem_fetch_pkg.sv - shared constants, FSM encoding and address decode helpers for imem_fetch
package imem_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    // depth must be a power of two, so the mask yields addr[log2(depth)+1:2]
    function automatic logic [31:0] addr_word_idx(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 2) & (depth - 32'd1);
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 2) < depth;
    endfunction

    function automatic logic addr_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// rtl/imem_fetch_if.sv - fetch/preload bus between the core (master) and imem_fetch (slave)
interface imem_fetch_if;
    logic [31:0] ip_instr_addr;
    logic        ip_load_en;
    logic [31:0] ip_load_addr;
    logic [31:0] ip_load_data;
    logic [31:0] op_instr;
    logic        op_instr_valid;
    logic        op_addr_err;

    modport master (
        output ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        input  op_instr, op_instr_valid, op_addr_err
    );

    modport slave (
        input  ip_instr_addr, ip_load_en, ip_load_addr, ip_load_data,
        output op_instr, op_instr_valid, op_addr_err
    );
endinterface

// File: rtl/imem_fetch_array.sv
// rtl/imem_fetch_array.sv - DEPTH x 32 instruction store, synchronous write, combinational read
module imem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction fetch stage: tracks the PC, waits LATENCY cycles, returns the word
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic clk,
    input  logic rst,
    imem_fetch_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [2:0]  LAST_CNT = 3'(LATENCY - 1);

    fetch_state_t r_state;
    logic [31:0]  r_req_addr;
    logic [2:0]   r_cnt;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic         r_err;

    logic          w_mismatch;
    logic          w_load_ok;
    logic [AW-1:0] w_load_idx;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_new_idx;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rd_addr;
    logic [31:0]   w_rd_data;
    logic          w_rd_ok;
    logic          w_load_hit;
    logic          w_load_new;
    logic          w_complete;

    assign w_mismatch = bus.ip_instr_addr != r_req_addr;
    assign w_load_ok  = bus.ip_load_en && !rst && addr_in_range(bus.ip_load_addr, DEPTH);
    assign w_load_idx = AW'(addr_word_idx(bus.ip_load_addr, DEPTH));
    assign w_req_idx  = AW'(addr_word_idx(r_req_addr, DEPTH));
    assign w_new_idx  = AW'(addr_word_idx(bus.ip_instr_addr, DEPTH));

    assign w_load_hit = w_load_ok && addr_in_range(r_req_addr, DEPTH) && (w_load_idx == w_req_idx);
    assign w_load_new = w_load_ok && addr_in_range(bus.ip_instr_addr, DEPTH) && (w_load_idx == w_new_idx);

    assign w_rd_addr = w_mismatch ? bus.ip_instr_addr : r_req_addr;
    assign w_rd_idx  = w_mismatch ? w_new_idx : w_req_idx;
    assign w_rd_ok   = addr_in_range(w_rd_addr, DEPTH) && addr_aligned(w_rd_addr);

    // A same-cycle write to the new word defers completion one edge so the read sees the new data
    assign w_complete = w_mismatch ? ((LATENCY == 1) && !w_load_new)
                                   : (!w_load_hit && (r_state == ST_FETCH) && (r_cnt == LAST_CNT));

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_load_ok),
        .i_waddr (w_load_idx),
        .i_wdata (bus.ip_load_data),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_req_addr <= '0;
            r_cnt      <= '0;
            r_instr    <= NOP_WORD;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_req_addr <= bus.ip_instr_addr;
            end
            if (w_complete) begin
                r_instr <= w_rd_ok ? w_rd_data : NOP_WORD;
                r_err   <= !w_rd_ok;
                r_valid <= 1'b1;
                r_state <= ST_HOLD;
            end else if (w_mismatch) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                r_state <= ST_FETCH;
                r_cnt   <= (LATENCY == 1) ? 3'd0 : 3'd1;
            end else if (w_load_hit) begin
                r_valid <= 1'b0;
                r_state <= ST_FETCH;
                r_cnt   <= 3'd0;
            end else if (r_state == ST_FETCH) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // The live address compare keeps stale data from ever being flagged valid
    assign bus.op_instr       = r_instr;
    assign bus.op_instr_valid = r_valid && (r_state == ST_HOLD) && !w_mismatch;
    assign bus.op_addr_err    = r_err;
endmodule
